sdft_spectrum_streamer: RTL

//  Sink for the SDFT bin-write port (freqWrReal/Imag/Addr/En) emitted by sdft_top.

---
 rtl/sdft_pkg.sv | 32 +++
 rtl/sdft_bank_ram.sv | 39 +++
 rtl/sdft_spectrum_streamer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sdft_pkg.sv
// -----------------------------------------------------------------------------
// sdft_pkg
// Shared definitions for the SDFT spectrum streamer:
//   - default bin count, word width and overrun-counter width
//   - t_sdftBin: packed {imag, real} layout of one spectrum bin (default width)
//   - writer / reader FSM state encodings
// -----------------------------------------------------------------------------
package sdft_pkg;

    localparam int C_N_DEF     = 512;  // bins per frame
    localparam int C_W_DEF     = 32;   // width of each real / imag word
    localparam int C_CNT_W_DEF = 16;   // overrun counter width

    // One bin as it travels on the stream: imag in the upper half, real in the lower.
    typedef struct packed {
        logic [C_W_DEF-1:0] im;
        logic [C_W_DEF-1:0] re;
    } t_sdftBin;

    // Writer: W_SYNC waits for bin 0, W_FILL collects bins in strict order.
    typedef enum logic {
        W_SYNC = 1'b0,
        W_FILL = 1'b1
    } t_wrState;

    // Reader: R_STREAM while a handed-off frame is being replayed.
    typedef enum logic {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } t_rdState;

endpackage

// File: rtl/sdft_bank_ram.sv
// -----------------------------------------------------------------------------
// sdft_bank_ram
// Simple dual-port RAM holding both ping-pong banks. Address is {bank, bin}.
// One write port, one read port with a registered output (one-cycle latency),
// written so that it maps onto block RAM. Contents are never reset.
// Ports:
//   i_clk     clock
//   i_wrEn    write strobe          i_wrAddr / i_wrData  write address / data
//   i_rdEn    read strobe           i_rdAddr             read address
//   o_rdData  read data, valid the cycle after i_rdEn
// -----------------------------------------------------------------------------
module sdft_bank_ram #(
    parameter int g_AW = 10,
    parameter int g_DW = 64
) (
    input  logic            i_clk,
    input  logic            i_wrEn,
    input  logic [g_AW-1:0] i_wrAddr,
    input  logic [g_DW-1:0] i_wrData,
    input  logic            i_rdEn,
    input  logic [g_AW-1:0] i_rdAddr,
    output logic [g_DW-1:0] o_rdData
);

    logic [g_DW-1:0] r_mem [2**g_AW];

    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rdEn) begin
            o_rdData <= r_mem[i_rdAddr];
        end
    end

endmodule

// File: rtl/sdft_spectrum_streamer.sv
// -----------------------------------------------------------------------------
// sdft_spectrum_streamer
// Collects SDFT bin writes (bins 0..g_N-1, strictly in order) into one bank of a
// ping-pong RAM and replays each completed frame as an AXI-stream of {imag,real}
// beats. Bin writes never stall; a frame completed while the previous one is
// still streaming is dropped and counted.
// Ports:
//   i_clk, i_resetN                 clock, asynchronous active-low reset
//   i_freqWrReal/Imag/Addr/En       bin write port (no backpressure)
//   o_axisData/Valid/Last/User      stream out; Last on bin g_N-1, User on bin 0
//   i_axisReady                     stream backpressure
//   o_seqErr                        1-cycle pulse after an out-of-order bin write
//   o_overrunCnt                    saturating count of dropped complete frames
// -----------------------------------------------------------------------------
module sdft_spectrum_streamer
    import sdft_pkg::*;
#(
    parameter int g_N     = C_N_DEF,
    parameter int g_W     = C_W_DEF,
    parameter int g_CNT_W = C_CNT_W_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_resetN,
    input  logic [g_W-1:0]          i_freqWrReal,
    input  logic [g_W-1:0]          i_freqWrImag,
    input  logic [$clog2(g_N)-1:0]  i_freqWrAddr,
    input  logic                    i_freqWrEn,
    output logic [2*g_W-1:0]        o_axisData,
    output logic                    o_axisValid,
    input  logic                    i_axisReady,
    output logic                    o_axisLast,
    output logic                    o_axisUser,
    output logic                    o_seqErr,
    output logic [g_CNT_W-1:0]      o_overrunCnt
);

    localparam int              AW         = $clog2(g_N);
    localparam int              DW         = 2 * g_W;
    localparam logic [AW-1:0]   C_LAST_BIN = AW'(g_N - 1);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } t_beat;

    // Writer state
    t_wrState       r_wrState;
    logic [AW-1:0]  r_wrCnt;
    logic           r_wrBank;

    // Reader state
    t_rdState       r_rdState;
    logic [AW-1:0]  r_rdCnt;
    logic           r_rdAllIssued;
    logic           r_rdBank;
    logic           r_rdPend;       // a RAM read was issued last cycle
    logic [AW-1:0]  r_rdPendIdx;    // bin index of that read

    // Two-entry skid FIFO between RAM and output register (entry 0 = head)
    t_beat          r_skid [2];
    logic [1:0]     r_skidCnt;

    logic [DW-1:0]  w_ramData;
    t_beat          w_ramBeat;
    logic           w_inOrder, w_startBin, w_store, w_seqErr, w_complete;
    logic           w_lastAccept, w_rdFree, w_handoff;
    logic           w_skidRoom, w_rdIssue;
    logic           w_outLoad, w_pop, w_bypass, w_push;

    // ---------------- writer decode ----------------
    // In W_FILL r_wrCnt is never 0, so an addr-0 write there is always a restart.
    assign w_inOrder    = i_freqWrEn && (r_wrState == W_FILL) && (i_freqWrAddr == r_wrCnt);
    assign w_startBin   = i_freqWrEn && (i_freqWrAddr == '0);
    assign w_store      = w_inOrder || w_startBin;
    assign w_seqErr     = i_freqWrEn && (r_wrState == W_FILL) && !w_inOrder;
    assign w_complete   = w_inOrder && (i_freqWrAddr == C_LAST_BIN);

    // The reader can take a new frame if idle, or if its final beat leaves this cycle.
    assign w_lastAccept = o_axisValid && o_axisLast && i_axisReady;
    assign w_rdFree     = (r_rdState == R_IDLE) || w_lastAccept;
    assign w_handoff    = w_complete && w_rdFree;

    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            r_wrState    <= W_SYNC;
            r_wrCnt      <= '0;
            r_wrBank     <= 1'b0;
            o_seqErr     <= 1'b0;
            o_overrunCnt <= '0;
        end else begin
            o_seqErr <= w_seqErr;
            if (w_complete) begin
                r_wrState <= W_SYNC;
                if (w_rdFree) begin
                    r_wrBank <= ~r_wrBank;
                end else if (o_overrunCnt != '1) begin
                    // Dropped frame: its bank is simply overwritten by the next one.
                    o_overrunCnt <= o_overrunCnt + 1'b1;
                end
            end else if (w_startBin) begin
                r_wrState <= W_FILL;
                r_wrCnt   <= AW'(1);
            end else if (w_inOrder) begin
                r_wrCnt   <= r_wrCnt + AW'(1);
            end else if (w_seqErr) begin
                r_wrState <= W_SYNC;
            end
        end
    end

    // ---------------- reader ----------------
    // Issue a read only if the skid can absorb it even when the output stalls:
    // entries held plus the read already in flight must leave one slot free.
    assign w_skidRoom = (r_skidCnt + {1'b0, r_rdPend}) < 2'd2;
    assign w_rdIssue  = (r_rdState == R_STREAM) && !r_rdAllIssued && w_skidRoom;

    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            r_rdState     <= R_IDLE;
            r_rdCnt       <= '0;
            r_rdAllIssued <= 1'b0;
            r_rdBank      <= 1'b0;
            r_rdPend      <= 1'b0;
            r_rdPendIdx   <= '0;
        end else begin
            r_rdPend    <= w_rdIssue;
            r_rdPendIdx <= r_rdCnt;
            if (w_handoff) begin
                r_rdState     <= R_STREAM;
                r_rdBank      <= r_wrBank;
                r_rdCnt       <= '0;
                r_rdAllIssued <= 1'b0;
            end else begin
                if (w_lastAccept) begin
                    r_rdState <= R_IDLE;
                end
                if (w_rdIssue) begin
                    r_rdCnt <= r_rdCnt + AW'(1);
                    if (r_rdCnt == C_LAST_BIN) begin
                        r_rdAllIssued <= 1'b1;
                    end
                end
            end
        end
    end

    sdft_bank_ram #(
        .g_AW (AW + 1),
        .g_DW (DW)
    ) u_ram (
        .i_clk    (i_clk),
        .i_wrEn   (w_store),
        .i_wrAddr ({r_wrBank, i_freqWrAddr}),
        .i_wrData ({i_freqWrImag, i_freqWrReal}),
        .i_rdEn   (w_rdIssue),
        .i_rdAddr ({r_rdBank, r_rdCnt}),
        .o_rdData (w_ramData)
    );

    assign w_ramBeat = {w_ramData, (r_rdPendIdx == C_LAST_BIN), (r_rdPendIdx == '0)};

    // ---------------- skid + output register ----------------
    // Head of skid has priority; RAM data bypasses the skid only when it is empty.
    assign w_outLoad = !o_axisValid || i_axisReady;
    assign w_pop     = w_outLoad && (r_skidCnt != 2'd0);
    assign w_bypass  = w_outLoad && (r_skidCnt == 2'd0) && r_rdPend;
    assign w_push    = r_rdPend && !w_bypass;

    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            o_axisValid <= 1'b0;
            o_axisData  <= '0;
            o_axisLast  <= 1'b0;
            o_axisUser  <= 1'b0;
        end else if (w_outLoad) begin
            if (w_pop) begin
                o_axisValid <= 1'b1;
                {o_axisData, o_axisLast, o_axisUser} <= r_skid[0];
            end else if (w_bypass) begin
                o_axisValid <= 1'b1;
                {o_axisData, o_axisLast, o_axisUser} <= w_ramBeat;
            end else begin
                o_axisValid <= 1'b0;
                o_axisLast  <= 1'b0;
                o_axisUser  <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            r_skid[0] <= '0;
            r_skid[1] <= '0;
            r_skidCnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_skidCnt == 2'd1) begin
                        r_skid[0] <= w_ramBeat;
                    end else begin
                        r_skid[0] <= r_skid[1];
                        r_skid[1] <= w_ramBeat;
                    end
                end
                2'b01: begin
                    r_skid[0] <= r_skid[1];
                    r_skidCnt <= r_skidCnt - 2'd1;
                end
                2'b10: begin
                    r_skid[r_skidCnt[0]] <= w_ramBeat;
                    r_skidCnt            <= r_skidCnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
